sync_fifo: RTL and testbench
============================

// Module: sync_fifo
//
// PURPOSE
// - Parametrised single-clock FIFO. Register-file storage plus read/write
//   pointer control, occupancy count and full/empty/almost flags.
// - Sits between the UART RX/TX byte paths and their consumers/producers
//   (command decoder, sensor/clock data formatter).
// - Supersedes bare register-file use: callers push/pop, not address.
//
// PARAMETERS
// - DATA_WIDTH  8   width of each stored word
// - ADDR_WIDTH  4   pointer width; DEPTH = 2**ADDR_WIDTH entries (16)
// - AF_LEVEL    12  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
// - AE_LEVEL    2   almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// PORTS
// - clk           in   1             rising-edge clock
// - rst           in   1             synchronous active-high reset
// - push          in   1             write request
// - wdata         in   DATA_WIDTH    write data, sampled with push
// - pop           in   1             read request (acknowledges rdata)
// - rdata         out  DATA_WIDTH    head word, show-ahead (valid when !empty)
// - full          out  1             count == DEPTH
// - empty         out  1             count == 0
// - almost_full   out  1             count >= AF_LEVEL
// - almost_empty  out  1             count <= AE_LEVEL
// - count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
// - overflow      out  1             [SYNC_FIFO_STATUS_EN only] sticky
// - underflow     out  1             [SYNC_FIFO_STATUS_EN only] sticky
//
// BEHAVIOUR
// - Reset (rst=1 at posedge) has priority over push/pop. It clears wptr,
//   rptr and count to 0. Outputs after reset: empty=1, full=0, almost_empty=1,
//   almost_full=0, count=0. Storage is not cleared.
// - Accepted write: wr_ok = push & (!full | pop). Accepted read: rd_ok = pop & !empty.
// - wr_ok: mem[wptr] <= wdata; wptr <= wptr+1, wrapping modulo DEPTH.
// - rd_ok: rptr <= rptr+1, wrapping modulo DEPTH.
// - count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
// - Full with push & pop: both accepted, count stays DEPTH, full stays 1.
// - Empty with push & pop: pop is ignored and the push is accepted; count becomes 1.
// - Push while full without pop: write dropped; storage and pointers unchanged.
// - Pop while empty: no pointer change.
// - rdata = mem[rptr], combinational read. A word is visible the cycle after
//   its write when the FIFO was empty; it changes the cycle after rd_ok.
//   rdata is don't-care while empty.
// - All flags are registered or derived from the registered count; there is
//   no combinational path from push/pop to any flag.
// - Latency: write-to-readable is 1 cycle. Read acknowledge is 0 cycles (show-ahead).
//
// CONFIGURATION
// - SYNC_FIFO_STATUS_EN defined:
//   - overflow is set on push & full & !pop.
//   - underflow is set on pop & empty.
//   - Both are sticky until rst and reset to 0.
// - SYNC_FIFO_STATUS_EN undefined: the overflow/underflow ports and their logic
//   are absent. Illegal requests are still silently ignored.
//
// TESTING
// - Reset then idle -> empty=1, full=0, count=0, almost_empty=1. With the
//   macro: overflow=0, underflow=0.
// - Push 0x11,0x22,0x33 on consecutive cycles, then pop 3 -> rdata sequence
//   0x11,0x22,0x33; count 1,2,3,2,1,0; empty=1 at the end.
// - Push 16 words 0x00..0x0F -> full=1, count=16, almost_full from count=12.
//   17th push 0xAA -> dropped; with the macro overflow=1. Pop 16 -> 0x00..0x0F.
// - Wrap: 10 push / 10 pop, then 10 push / 10 pop -> pointers wrap past 15;
//   data is returned in order and count never exceeds 10.
// - Simultaneous push+pop: when full, count stays 16 and the new word is the
//   last one out. When empty, count=1 and rdata=wdata the next cycle.
// - Pop while empty -> count stays 0; with the macro underflow=1. Assert rst
//   mid-stream with count=5 -> count=0, empty=1 on the next cycle.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and full/empty/almost flags.
// Define SYNC_FIFO_STATUS_EN to add sticky overflow/underflow status outputs.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_STATUS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FullCount = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AfLevel   = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AeLevel   = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CountOne  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wrOk;
    logic                  rdOk;

    // Flags depend only on the registered count, never on push/pop directly.
    assign full         = (count_q == FullCount);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfLevel);
    assign almost_empty = (count_q <= AeLevel);
    assign count        = count_q;
    assign rdata        = mem_q[rdPtr_q];

    // A pop while full frees the slot the concurrent push lands in.
    assign wrOk = push & (~full | pop);
    assign rdOk = pop & ~empty;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrOk) begin
            wrPtr_d = wrPtr_q + PtrOne;
        end
        if (rdOk) begin
            rdPtr_d = rdPtr_q + PtrOne;
        end
        case ({wrOk, rdOk})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wrOk) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

`ifdef SYNC_FIFO_STATUS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (push & full & ~pop);
        underflow_d = underflow_q | (pop & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: table-driven vectors, a data scoreboard
// queue and hand-written corner sequences. Honours SYNC_FIFO_STATUS_EN.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
`ifdef SYNC_FIFO_STATUS_EN
    logic       overflow, underflow;
`endif

    sync_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AF_LEVEL(12),
        .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .wdata(wdata),
        .pop(pop),
        .rdata(rdata),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count)
`ifdef SYNC_FIFO_STATUS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] wdata;
        int         expCount;
        logic       expEmpty;
        logic       expAe;
    } vec_t;

    int         tests = 0;
    int         failures = 0;
    int         modelCount = 0;
    logic [7:0] sb[$];
    logic       modelOvf = 1'b0;
    logic       modelUnf = 1'b0;
    vec_t       vecs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Compare every status output against the reference occupancy model.
    task automatic checkOutput();
        check("count", 32'(count), 32'(modelCount));
        check("empty", 32'(empty), 32'(modelCount == 0));
        check("full", 32'(full), 32'(modelCount == 16));
        check("almost_full", 32'(almost_full), 32'(modelCount >= 12));
        check("almost_empty", 32'(almost_empty), 32'(modelCount <= 2));
`ifdef SYNC_FIFO_STATUS_EN
        check("overflow", 32'(overflow), 32'(modelOvf));
        check("underflow", 32'(underflow), 32'(modelUnf));
`endif
    endtask

    // One clock of stimulus: drive at negedge, check show-ahead data before the
    // edge, update the model at the edge, then check flags just after it.
    task automatic applyStimulus(input logic p, input logic q, input logic [7:0] d);
        logic wr;
        logic rd;
        @(negedge clk);
        push  = p;
        pop   = q;
        wdata = d;
        #1;
        wr = p && (modelCount < 16 || q);
        rd = q && (modelCount > 0);
        if (rd) begin
            check("rdata", 32'(rdata), 32'(sb[0]));
        end
        @(posedge clk);
        if (p && modelCount == 16 && !q) modelOvf = 1'b1;
        if (q && modelCount == 0) modelUnf = 1'b1;
        if (rd) void'(sb.pop_front());
        if (wr) sb.push_back(d);
        if (wr && !rd) modelCount++;
        if (rd && !wr) modelCount--;
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        @(posedge clk);
        modelCount = 0;
        sb.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'h33, 3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].wdata);
            check("vec_count", 32'(count), 32'(vecs[i].expCount));
            check("vec_empty", 32'(empty), 32'(vecs[i].expEmpty));
            check("vec_ae", 32'(almost_empty), 32'(vecs[i].expAe));
        end
`ifdef SYNC_FIFO_STATUS_EN
        check("underflow_set", 32'(underflow), 32'(1));
`endif

        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i));
            check("fill_af", 32'(almost_full), 32'(i + 1 >= 12));
        end
        check("fill_full", 32'(full), 32'(1));
        applyStimulus(1'b1, 1'b0, 8'hAA);
        check("drop_count", 32'(count), 32'(16));
`ifdef SYNC_FIFO_STATUS_EN
        check("overflow_set", 32'(overflow), 32'(1));
`endif
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        check("drain_empty", 32'(empty), 32'(1));

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
        applyStimulus(1'b1, 1'b1, 8'hBB);
        check("full_pp_count", 32'(count), 32'(16));
        check("full_pp_full", 32'(full), 32'(1));
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        check("last_is_bb", 32'(rdata), 32'(8'hBB));
        applyStimulus(1'b0, 1'b1, 8'h00);

        applyStimulus(1'b1, 1'b1, 8'h5A);
        check("empty_pp_count", 32'(count), 32'(1));
        check("empty_pp_rdata", 32'(rdata), 32'(8'h5A));
        applyStimulus(1'b0, 1'b1, 8'h00);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h80 + 16 * r + i));
            check("wrap_count", 32'(count), 32'(10));
            for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        end

        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 8'($urandom));
        end

        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i));
        check("pre_rst_count", 32'(count), 32'(5));
        doReset();
        check("mid_rst_empty", 32'(empty), 32'(1));
        applyStimulus(1'b1, 1'b0, 8'h77);
        applyStimulus(1'b0, 1'b1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
